// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - redirect request and stage-1 PC bundle for fetch_redirect_ctrl
interface fetch_redirect_ctrl_if;
    logic        ready;
    logic        hold_pc;
    logic        except_valid;
    logic [31:0] except_vec;
    logic        dmis_valid;
    logic [31:0] dmis_target;
    logic        rmis_valid;
    logic [31:0] rmis_target;
    logic        hold_resolved;
    logic        pres_valid;
    logic [31:0] pres_target;
    logic        replay_valid;
    logic [31:0] replay_vaddr;
    logic        pred_valid;
    logic [31:0] pred_target;
    logic        pred_delayed;
    logic [31:0] pc;
    logic        pc_en;
    logic        ds_pending;

    modport master (
        output ready, hold_pc,
        output except_valid, except_vec, dmis_valid, dmis_target,
        output rmis_valid, rmis_target, hold_resolved,
        output pres_valid, pres_target, replay_valid, replay_vaddr,
        output pred_valid, pred_target, pred_delayed,
        input  pc, pc_en, ds_pending
    );

    modport slave (
        input  ready, hold_pc,
        input  except_valid, except_vec, dmis_valid, dmis_target,
        input  rmis_valid, rmis_target, hold_resolved,
        input  pres_valid, pres_target, replay_valid, replay_vaddr,
        input  pred_valid, pred_target, pred_delayed,
        output pc, pc_en, ds_pending
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch PC sequencer with prioritised redirect arbitration
// Optional per-source applied-redirect counters: define FETCH_REDIRECT_STATS_EN.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int          FETCH_NUM = 2,
    parameter int          NSRC      = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_redirect_ctrl_if.slave bus
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]          redirect_cnt [NSRC]
`endif
);
    localparam int          PW        = $clog2(NSRC);
    localparam logic [31:0] GRP_BYTES = 32'(4 * FETCH_NUM);

    // Larger value means higher priority.
    localparam logic [PW-1:0] P_EXC  = PW'(5);
    localparam logic [PW-1:0] P_DMIS = PW'(4);
    localparam logic [PW-1:0] P_RMIS = PW'(3);
    localparam logic [PW-1:0] P_PRES = PW'(2);
    localparam logic [PW-1:0] P_REPL = PW'(1);
    localparam logic [PW-1:0] P_PRED = PW'(0);

    typedef enum logic [1:0] {S_RUN, S_WAIT_DS, S_PEND} state_t;

    state_t        state, state_nx;
    logic [31:0]   pc_q, pc_nx;
    logic          pc_en_q, pc_en_nx;
    logic          pend_valid, pend_valid_nx;
    logic [PW-1:0] pend_prio, pend_prio_nx;
    logic [31:0]   pend_target, pend_target_nx;
    logic          pend_ds, pend_ds_nx;
    logic [31:0]   ds_target, ds_target_nx;

    logic          adv, rmis_eff, hi_win, take_cur;
    logic          win_valid, win_ds;
    logic [PW-1:0] win_prio, sel_prio, apply_prio;
    logic [31:0]   win_target, sel_target, seq_pc;
    logic          sel_ds, apply_valid;

    // A bubble cycle (pc_en low) issued no fetch, so it cannot advance the PC.
    assign adv      = bus.ready & ~bus.hold_pc & pc_en_q;
    assign rmis_eff = bus.rmis_valid & ~bus.hold_resolved;
    assign seq_pc   = (pc_q & ~(GRP_BYTES - 32'd1)) + GRP_BYTES;

    always_comb begin
        win_valid  = 1'b1;
        win_prio   = P_PRED;
        win_target = bus.pred_target;
        win_ds     = 1'b0;
        if (bus.except_valid) begin
            win_prio   = P_EXC;
            win_target = bus.except_vec;
        end else if (bus.dmis_valid) begin
            win_prio   = P_DMIS;
            win_target = bus.dmis_target;
        end else if (rmis_eff) begin
            win_prio   = P_RMIS;
            win_target = bus.rmis_target;
        end else if (bus.pres_valid) begin
            win_prio   = P_PRES;
            win_target = bus.pres_target;
        end else if (bus.replay_valid) begin
            win_prio   = P_REPL;
            win_target = bus.replay_vaddr;
        end else if (bus.pred_valid) begin
            win_ds     = bus.pred_delayed;
        end else begin
            win_valid  = 1'b0;
        end
    end

    // Equal priority lets the newer request replace the pending one.
    assign take_cur   = win_valid & (~pend_valid | (win_prio >= pend_prio));
    assign sel_prio   = take_cur ? win_prio   : pend_prio;
    assign sel_target = take_cur ? win_target : pend_target;
    assign sel_ds     = take_cur ? win_ds     : pend_ds;
    assign hi_win     = win_valid & (win_prio != P_PRED);

    always_comb begin
        state_nx       = state;
        pc_nx          = pc_q;
        pc_en_nx       = 1'b1;
        pend_valid_nx  = pend_valid;
        pend_prio_nx   = pend_prio;
        pend_target_nx = pend_target;
        pend_ds_nx     = pend_ds;
        ds_target_nx   = ds_target;
        apply_valid    = 1'b0;
        apply_prio     = win_prio;
        unique case (state)
            S_RUN: begin
                if (adv) begin
                    if (win_valid && win_ds) begin
                        pc_nx        = seq_pc;
                        ds_target_nx = win_target;
                        state_nx     = S_WAIT_DS;
                    end else if (win_valid) begin
                        pc_nx       = win_target;
                        apply_valid = 1'b1;
                    end else begin
                        pc_nx = seq_pc;
                    end
                end else if (win_valid) begin
                    pend_valid_nx  = 1'b1;
                    pend_prio_nx   = win_prio;
                    pend_target_nx = win_target;
                    pend_ds_nx     = win_ds;
                    state_nx       = S_PEND;
                end
            end
            S_WAIT_DS: begin
                if (adv) begin
                    state_nx    = S_RUN;
                    apply_valid = 1'b1;
                    if (hi_win) begin
                        pc_nx = win_target;
                    end else begin
                        pc_nx      = ds_target;
                        apply_prio = P_PRED;
                    end
                end else if (hi_win) begin
                    pend_valid_nx  = 1'b1;
                    pend_prio_nx   = win_prio;
                    pend_target_nx = win_target;
                    pend_ds_nx     = 1'b0;
                    state_nx       = S_PEND;
                end
            end
            S_PEND: begin
                if (adv) begin
                    pend_valid_nx = 1'b0;
                    if (sel_ds) begin
                        pc_nx        = seq_pc;
                        ds_target_nx = sel_target;
                        state_nx     = S_WAIT_DS;
                    end else begin
                        pc_nx       = sel_target;
                        apply_valid = 1'b1;
                        apply_prio  = sel_prio;
                        state_nx    = S_RUN;
                    end
                end else begin
                    pend_prio_nx   = sel_prio;
                    pend_target_nx = sel_target;
                    pend_ds_nx     = sel_ds;
                end
            end
            default: state_nx = S_RUN;
        endcase
        // One-cycle fetch bubble so the exception flush can propagate.
        if (apply_valid && apply_prio == P_EXC) pc_en_nx = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RUN;
            pc_q        <= RESET_PC;
            pc_en_q     <= 1'b0;
            pend_valid  <= 1'b0;
            pend_prio   <= '0;
            pend_target <= '0;
            pend_ds     <= 1'b0;
            ds_target   <= '0;
        end else begin
            state       <= state_nx;
            pc_q        <= pc_nx;
            pc_en_q     <= pc_en_nx;
            pend_valid  <= pend_valid_nx;
            pend_prio   <= pend_prio_nx;
            pend_target <= pend_target_nx;
            pend_ds     <= pend_ds_nx;
            ds_target   <= ds_target_nx;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_en      = pc_en_q;
    assign bus.ds_pending = (state == S_WAIT_DS);

`ifdef FETCH_REDIRECT_STATS_EN
    // Index 0 counts exceptions, NSRC-1 counts predictions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) redirect_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (apply_valid && apply_prio == PW'(NSRC - 1 - i) && redirect_cnt[i] != '1)
                    redirect_cnt[i] <= redirect_cnt[i] + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] GRP      = 32'd8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if bus();
`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redirect_cnt [6];
`endif

    fetch_redirect_ctrl #(.RESET_PC(RESET_PC), .FETCH_NUM(2), .NSRC(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_REDIRECT_STATS_EN
        ,
        .redirect_cnt (redirect_cnt)
`endif
    );

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        en;
        logic        ds;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the expectation queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("sb_missed", 32'(e.cyc), 32'(cyc));
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("sb_pc", bus.pc, e.pc);
            check("sb_pc_en", 32'(bus.pc_en), 32'(e.en));
            check("sb_ds_pending", 32'(bus.ds_pending), 32'(e.ds));
        end
    end

    // Reference model: index 0 is the most urgent source; m_pend < 0 means nothing latched.
    logic [31:0] m_pc, m_ds_tgt, m_pend_tgt;
    bit          m_en, m_ds, m_pend_dly;
    int          m_pend;

    function automatic logic [31:0] next_group(input logic [31:0] a);
        return a - (a % GRP) + GRP;
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_en = 0; m_ds = 0; m_pend = -1;
        m_ds_tgt = '0; m_pend_tgt = '0; m_pend_dly = 0;
    endtask

    task automatic model_step();
        bit          req [6];
        logic [31:0] tgt [6];
        int          w;
        bit          adv, en_nx;
        req[0] = bus.except_valid;                       tgt[0] = bus.except_vec;
        req[1] = bus.dmis_valid;                         tgt[1] = bus.dmis_target;
        req[2] = bus.rmis_valid && !bus.hold_resolved;   tgt[2] = bus.rmis_target;
        req[3] = bus.pres_valid;                         tgt[3] = bus.pres_target;
        req[4] = bus.replay_valid;                       tgt[4] = bus.replay_vaddr;
        req[5] = bus.pred_valid;                         tgt[5] = bus.pred_target;
        w = -1;
        for (int i = 5; i >= 0; i--) if (req[i]) w = i;
        adv   = bus.ready && !bus.hold_pc && m_en;
        en_nx = 1;
        if (m_ds) begin
            if (w >= 0 && w < 5) begin
                if (adv) begin
                    m_pc  = tgt[w];
                    en_nx = (w != 0);
                end else begin
                    m_pend = w; m_pend_tgt = tgt[w]; m_pend_dly = 0;
                end
                m_ds = 0;
            end else if (adv) begin
                m_pc = m_ds_tgt;
                m_ds = 0;
            end
        end else begin
            if (w >= 0 && (m_pend < 0 || w <= m_pend)) begin
                m_pend = w; m_pend_tgt = tgt[w];
                m_pend_dly = (w == 5) && bus.pred_delayed;
            end
            if (adv) begin
                if (m_pend < 0) begin
                    m_pc = next_group(m_pc);
                end else if (m_pend_dly) begin
                    m_ds_tgt = m_pend_tgt;
                    m_pc     = next_group(m_pc);
                    m_ds     = 1;
                end else begin
                    m_pc  = m_pend_tgt;
                    en_nx = (m_pend != 0);
                end
                m_pend = -1;
            end
        end
        m_en = en_nx;
    endtask

    task automatic tick();
        if (!rst_n) model_reset();
        else        model_step();
        exp_q.push_back('{cyc + 1, m_pc, m_en, m_ds});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ready = 1; bus.hold_pc = 0; bus.hold_resolved = 0;
        bus.except_valid = 0; bus.except_vec = '0;
        bus.dmis_valid = 0;   bus.dmis_target = '0;
        bus.rmis_valid = 0;   bus.rmis_target = '0;
        bus.pres_valid = 0;   bus.pres_target = '0;
        bus.replay_valid = 0; bus.replay_vaddr = '0;
        bus.pred_valid = 0;   bus.pred_target = '0; bus.pred_delayed = 0;
    endtask

    // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset(input int n);
        rst_n = 0;
        #1;
        check("rst_async_pc", bus.pc, RESET_PC);
        check("rst_async_pc_en", 32'(bus.pc_en), 32'd0);
        check("rst_async_ds", 32'(bus.ds_pending), 32'd0);
        exp_q.delete();
        model_reset();
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(posedge clk);
        #1;
        do_reset(2);
        rst_n = 1;
        tick();
        check("rel_pc", bus.pc, 32'hBFC0_0000);
        check("rel_pc_en", 32'(bus.pc_en), 32'd1);
        tick();
        check("seq1", bus.pc, 32'hBFC0_0008);
        tick();
        check("seq2", bus.pc, 32'hBFC0_0010);

        bus.pred_valid = 1; bus.pred_delayed = 1; bus.pred_target = 32'h8000_1000;
        tick();
        check("ds_slot_pc", bus.pc, 32'hBFC0_0018);
        check("ds_slot_flag", 32'(bus.ds_pending), 32'd1);
        idle();
        tick();
        check("ds_target_pc", bus.pc, 32'h8000_1000);
        check("ds_done_flag", 32'(bus.ds_pending), 32'd0);

        bus.ready = 0; bus.pres_valid = 1; bus.pres_target = 32'h0000_1000;
        tick();
        check("stall_hold1", bus.pc, 32'h8000_1000);
        bus.pres_valid = 0; bus.rmis_valid = 1; bus.rmis_target = 32'h0000_2000;
        tick();
        check("stall_hold2", bus.pc, 32'h8000_1000);
        bus.rmis_valid = 0;
        tick();
        check("stall_hold3", bus.pc, 32'h8000_1000);
        bus.ready = 1;
        tick();
        check("pend_prio_pc", bus.pc, 32'h0000_2000);

        bus.rmis_valid = 1; bus.rmis_target = 32'h0000_3000; bus.hold_resolved = 1;
        tick();
        check("rmis_masked", bus.pc, 32'h0000_2008);
        bus.hold_resolved = 0;
        tick();
        check("rmis_taken", bus.pc, 32'h0000_3000);
        idle();

        bus.except_valid = 1; bus.except_vec = 32'h8000_0180;
        bus.dmis_valid = 1;   bus.dmis_target = 32'h0000_4000;
        bus.replay_valid = 1; bus.replay_vaddr = 32'h0000_5000;
        tick();
        check("exc_pc", bus.pc, 32'h8000_0180);
        check("exc_bubble", 32'(bus.pc_en), 32'd0);
        idle();
        tick();
        check("exc_after_pc", bus.pc, 32'h8000_0180);
        check("exc_after_en", 32'(bus.pc_en), 32'd1);
        tick();
        check("exc_resume", bus.pc, 32'h8000_0188);

        bus.dmis_valid = 1; bus.dmis_target = 32'hFFFF_FFF8;
        tick();
        check("wrap_pre", bus.pc, 32'hFFFF_FFF8);
        idle();
        tick();
        check("wrap", bus.pc, 32'h0000_0000);

        bus.pred_valid = 1; bus.pred_delayed = 1; bus.pred_target = 32'h1234_5678;
        tick();
        check("wait_ds_entry", 32'(bus.ds_pending), 32'd1);
        idle();
        do_reset(2);
        rst_n = 1;
        tick();
        check("rel2_pc", bus.pc, RESET_PC);

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3));
                rst_n = 1;
            end
            bus.ready         = ($urandom_range(0, 3) != 0);
            bus.hold_pc       = ($urandom_range(0, 5) == 0);
            bus.hold_resolved = ($urandom_range(0, 2) == 0);
            bus.except_valid  = ($urandom_range(0, 24) == 0);
            bus.dmis_valid    = ($urandom_range(0, 12) == 0);
            bus.rmis_valid    = ($urandom_range(0, 9) == 0);
            bus.pres_valid    = ($urandom_range(0, 10) == 0);
            bus.replay_valid  = ($urandom_range(0, 12) == 0);
            bus.pred_valid    = ($urandom_range(0, 4) == 0);
            bus.pred_delayed  = ($urandom_range(0, 1) == 0);
            bus.except_vec    = $urandom();
            bus.dmis_target   = $urandom();
            bus.rmis_target   = $urandom();
            bus.pres_target   = $urandom();
            bus.replay_vaddr  = $urandom();
            bus.pred_target   = $urandom();
            tick();
        end

        idle();
        tick();
        tick();
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
